// File: rtl/moore_seq_generator.sv
// moore_seq_generator: Moore-style bit-serial pattern generator.
// Captures a PAT_W-bit pattern and a repeat count on start, then shifts the
// pattern out MSB-first for the requested number of repetitions. An optional
// idle gap of GAP_CYC cycles separates repetitions.
// Optional feature macro: SEQ_GEN_PARITY_EN -- when defined, every repetition
// is followed by one even-parity bit (XOR of the captured pattern).
//
// Output timing: d_out/d_valid/busy/done are registers loaded from the next
// state, so they reflect the state the machine is in during that cycle and
// there is no combinational path from any input to any output.
// dbg_state exposes the state register for observation.
module moore_seq_generator #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP_CYC  = 0,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int IW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  // Gap counter holds GAP_CYC-1 down to 0.
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_GAP    = 3'd2,
`ifdef SEQ_GEN_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_DONE   = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             rep_end;

  logic d_out_q, d_out_d;
  logic d_valid_q, d_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    rep_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A zero repeat count is a no-op request.
        if (start && (repeat_cnt != '0)) begin
          pat_d   = pattern;
          reps_d  = repeat_cnt;
          idx_d   = IW'(PAT_W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PARITY;
`else
          rep_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: rep_end = 1'b1;
`endif
      S_GAP: begin
        if (gap_q == '0) state_d = S_SHIFT;
        else             gap_d   = gap_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // End of one repetition: either start the next one or finish. reps is
    // left at 1 on the final repetition so it never wraps.
    if (rep_end) begin
      if (reps_q > CNT_W'(1)) begin
        reps_d = reps_q - 1'b1;
        idx_d  = IW'(PAT_W - 1);
        if (GAP_CYC > 0) begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYC - 1);
        end else begin
          state_d = S_SHIFT;
        end
      end else begin
        state_d = S_DONE;
      end
    end

    // Outputs for the cycle the machine is about to enter.
    d_out_d   = IDLE_BIT;
    d_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_SHIFT: begin
        d_out_d   = pat_d[idx_d];
        d_valid_d = 1'b1;
        busy_d    = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        d_out_d   = ^pat_d;
        d_valid_d = 1'b1;
        busy_d    = 1'b1;
      end
`endif
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      reps_q    <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      d_out_q   <= IDLE_BIT;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      reps_q    <= reps_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign d_out     = d_out_q;
  assign d_valid   = d_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
